// File: rtl/apb_master.sv
// apb_master: APB initiator for the 8-bit APB subsystem.
// Converts single-cycle local requests into APB SETUP/ACCESS cycles.
// It drives two slave selects. The MSB of the address picks PSEL2 over PSEL1.
// Optional feature: define APB_TIMEOUT_EN to abort an ACCESS that waits
// TIMEOUT_CYCLES cycles for PREADY. Such a transfer completes with done and err.
// Without the macro the timeout logic is held constant at zero, so err is always 0.
module apb_master #(
    parameter int unsigned ADDR_W         = 8,
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              done,
    output logic              err,
    output logic              PSEL1,
    output logic              PSEL2,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY
);

`ifdef APB_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                psel1_q, psel1_d;
    logic                psel2_q, psel2_d;
    logic                penable_q, penable_d;
    logic                pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    // req_ready decodes registered state plus PREADY; it cannot be a flop
    // because a completing ACCESS cycle must accept a back-to-back request.
    assign req_ready = (state_q == IDLE) || ((state_q == ACCESS) && PREADY);

    assign PSEL1   = psel1_q;
    assign PSEL2   = psel2_q;
    assign PENABLE = penable_q;
    assign PWRITE  = pwrite_q;
    assign PADDR   = paddr_q;
    assign PWDATA  = pwdata_q;
    assign rd_data = rd_data_q;
    assign done    = done_q;
    assign err     = err_q;

    // Next-state and next-output logic for the IDLE/SETUP/ACCESS sequencer
    always_comb begin
        state_d   = state_q;
        psel1_d   = psel1_q;
        psel2_d   = psel2_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        rd_data_d = rd_data_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        cnt_d     = cnt_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d   = SETUP;
                    psel1_d   = ~req_addr[ADDR_W-1];
                    psel2_d   = req_addr[ADDR_W-1];
                    penable_d = 1'b0;
                    pwrite_d  = req_write;
                    paddr_d   = req_addr;
                    pwdata_d  = req_write ? req_wdata : {DATA_W{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
                cnt_d     = {CNT_W{1'b0}};
            end
            ACCESS: begin
                if (PREADY) begin
                    done_d = 1'b1;
                    if (!pwrite_q) begin
                        rd_data_d = PRDATA;
                    end else begin
                        rd_data_d = rd_data_q;
                    end
                    if (req_valid) begin
                        // Back-to-back: go straight to SETUP of the next transfer
                        state_d   = SETUP;
                        psel1_d   = ~req_addr[ADDR_W-1];
                        psel2_d   = req_addr[ADDR_W-1];
                        penable_d = 1'b0;
                        pwrite_d  = req_write;
                        paddr_d   = req_addr;
                        pwdata_d  = req_write ? req_wdata : {DATA_W{1'b0}};
                    end else begin
                        state_d   = IDLE;
                        psel1_d   = 1'b0;
                        psel2_d   = 1'b0;
                        penable_d = 1'b0;
                    end
                end else if (TIMEOUT_EN && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1))) begin
                    // Last permitted wait cycle expired: abort without touching rd_data
                    state_d   = IDLE;
                    psel1_d   = 1'b0;
                    psel2_d   = 1'b0;
                    penable_d = 1'b0;
                    done_d    = 1'b1;
                    err_d     = 1'b1;
                end else if (TIMEOUT_EN) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d   = IDLE;
                psel1_d   = 1'b0;
                psel2_d   = 1'b0;
                penable_d = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= IDLE;
            psel1_q   <= 1'b0;
            psel2_q   <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= {ADDR_W{1'b0}};
            pwdata_q  <= {DATA_W{1'b0}};
            rd_data_q <= {DATA_W{1'b0}};
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= {CNT_W{1'b0}};
        end else begin
            state_q   <= state_d;
            psel1_q   <= psel1_d;
            psel2_q   <= psel2_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            rd_data_q <= rd_data_d;
            done_q    <= done_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule
